mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage RV32I pipeline. Consumes ex_mem_bus_t from the EX/MEM register and runs
//  LB/LH/LW/LBU/LHU/SB/SH/SW on the data-memory port with a valid/ready request and a response strobe.
//  Produces mem_wb_bus_t for the MEM/WB register. Raises stall_req, which holds EX/MEM and upstream stages.
//  Non-memory instructions pass through with zero added latency.
// PARAMETERS
//  XLEN        32   datapath/address width
//  TIMEOUT     256  cycles in RESP with no dmem_rsp_valid before an access fault is forced
// PORTS
//  ACLK            in   1     clock
//  ARESETn         in   1     asynchronous active-low reset
//  ex_mem_bus_in   in   pkg   instruction from EX/MEM: valid, mem_rd, mem_wr, funct3, alu_result(addr), rs2_data, rd, reg_wr
//  mem_wb_bus_out  out  pkg   to MEM/WB: valid, rd, reg_wr, wb_data, misaligned, access_fault
//  stall_req       out  1     1 = hold EX/MEM and upstream (drives their stall_en)
//  dmem_req_valid  out  1     request valid
//  dmem_req_ready  in   1     memory accepts request
//  dmem_addr       out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
//  dmem_we         out  1     1 = store
//  dmem_wstrb      out  4     byte enables (0 for loads)
//  dmem_wdata      out  XLEN  lane-aligned store data
//  dmem_rsp_valid  in   1     response/ack strobe, one cycle
//  dmem_rsp_rdata  in   XLEN  read word
//  dmem_rsp_err    in   1     bus error, qualified by rsp_valid
// BEHAVIOUR
//  Reset: ARESETn is asynchronous, active-low; clock is ACLK. Reset forces state=IDLE, rdata_q=0, err_q=0,
//   timeout counter=0. Reset mid-access abandons the access; a late response is ignored.
//  Outputs are combinational from the bus and state. Outputs are 0 after reset because the bus is 0.
//  mem_op = valid & (mem_rd|mem_wr). Misaligned if (half & addr[0]) | (word & addr[1:0]!=0).
//  FSM:
//   IDLE: mem_op & !misaligned -> dmem_req_valid=1, stall_req=1; ready=1 -> RESP, else -> REQ.
//         misaligned -> no request, stall_req=0, output misaligned=1, reg_wr=0. Not mem_op -> pass-through.
//   REQ:  hold req_valid=1 with addr/we/wstrb/wdata stable, stall_req=1; ready -> RESP.
//   RESP: req_valid=0, stall_req=1, counter++.
//         rsp_valid -> capture rdata_q and err_q -> DONE.
//         counter==TIMEOUT-1 -> err_q=1 -> DONE.
//   DONE: stall_req=0. Output is built from rdata_q/err_q -> IDLE. No re-issue even though the bus still holds the same instruction.
//  A response arriving in the same cycle as acceptance is illegal (response >= 1 cycle after acceptance). One outstanding access.
//  Store: wstrb SB=4'b0001<<a[1:0], SH=4'b0011<<a[1:0], SW=4'hF. wdata replicates the byte or half across lanes.
//  Load: select byte/half by a[1:0]. LB/LH sign-extend, LBU/LHU zero-extend.
//  Output: load -> wb_data=formatted. Other ops -> wb_data=alu_result.
//  err_q -> access_fault=1 and reg_wr=0.
//  Min latency with ready=1 and 1-cycle response: 3 cycles (IDLE, RESP, DONE).
// STRUCTURE
//  Package rv32i_pkg: ex_mem_bus_t, mem_wb_bus_t, funct3 constants F3_LB..F3_LHU, F3_SB..F3_SW, mem_state_e.
//  Sub-module lsu_align: combinational store lane alignment and strobes, load extraction and extension, misalign detect.
// TESTING
//  1. SW x=0xDEADBEEF @0x100, ready=1, ack next cycle -> wstrb=F, addr=0x100, stall high 2 cycles, then DONE.
//  2. LB @0x103, rdata=0x80xxxxxx -> wb_data=0xFFFFFF80. LBU -> 0x00000080.
//  3. SH 0x1234 @0x102 -> wstrb=4'b1100, wdata=0x12341234.
//  4. LW @0x102 -> no req_valid, misaligned=1, reg_wr=0, stall_req never asserted.
//  5. ready low 3 cycles, then rsp_err -> addr held stable, access_fault=1, reg_wr=0.
//     No response for TIMEOUT cycles -> access_fault=1.
//  6. ARESETn low during RESP -> state IDLE, req_valid=0. Late rsp_valid ignored.
//     ALU op (valid, no mem) -> wb_data=alu_result, stall_req=0 in the same cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared types for the RV32I pipeline MEM stage:
//   ex_mem_bus_t  - instruction state latched in the EX/MEM register
//   mem_wb_bus_t  - result handed to the MEM/WB register
//   F3_*          - funct3 encodings of the load/store instructions
//   mem_state_e   - MEM stage access sequencer states
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic            valid;
        logic            mem_rd;
        logic            mem_wr;
        logic [2:0]      funct3;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] rs2_data;
        logic [4:0]      rd;
        logic            reg_wr;
    } ex_mem_bus_t;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic            reg_wr;
        logic [XLEN-1:0] wb_data;
        logic            misaligned;
        logic            access_fault;
    } mem_wb_bus_t;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane handling for the MEM stage.
// Ports:
//   funct3      in   load/store size and signedness
//   addr_lo     in   low two address bits (byte offset within the word)
//   store_data  in   rs2 value to be stored
//   load_word   in   word returned by data memory
//   wstrb       out  byte enables for a store of this size/offset
//   wdata       out  store data replicated across all lanes of its size
//   load_data   out  selected byte/half/word, sign- or zero-extended
//   misaligned  out  half on odd address, or word not on a 4-byte boundary
// ---------------------------------------------------------------------------
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned
);

    logic [XLEN-1:0] shifted;

    // Byte offset moves the addressed lane down to bit 0.
    assign shifted = load_word >> {addr_lo, 3'b000};

    always_comb begin
        wstrb = 4'hF;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wstrb = 4'hF;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        load_data = load_word;
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'h0, shifted[7:0]};
            F3_LHU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = load_word;
        endcase
    end

    assign misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the 5-stage RV32I pipeline. Runs loads/stores on a
// valid/ready data-memory port with a single-cycle response strobe and
// holds the upstream pipeline via stall_req while an access is in flight.
// Non-memory instructions pass straight through combinationally.
// Ports:
//   ACLK, ARESETn     clock, asynchronous active-low reset
//   ex_mem_bus_in     instruction from the EX/MEM register
//   mem_wb_bus_out    result to the MEM/WB register
//   stall_req         1 = hold EX/MEM and all upstream stages
//   dmem_req_*        request channel (valid/ready, addr, we, wstrb, wdata)
//   dmem_rsp_*        response strobe with read data and bus error
// ---------------------------------------------------------------------------
module mem_access_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 256
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    input  ex_mem_bus_t     ex_mem_bus_in,
    output mem_wb_bus_t     mem_wb_bus_out,
    output logic            stall_req,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [3:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_rdata,
    input  logic            dmem_rsp_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    mem_state_e      state_q, state_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            mem_op;
    logic            misaligned;
    logic [3:0]      align_wstrb;
    logic [XLEN-1:0] align_wdata;
    logic [XLEN-1:0] load_data;

    assign mem_op = ex_mem_bus_in.valid & (ex_mem_bus_in.mem_rd | ex_mem_bus_in.mem_wr);

    // Load extraction works on the captured word, so the formatted result
    // is available in DONE regardless of what the bus does afterwards.
    lsu_align u_align (
        .funct3     (ex_mem_bus_in.funct3),
        .addr_lo    (ex_mem_bus_in.alu_result[1:0]),
        .store_data (ex_mem_bus_in.rs2_data),
        .load_word  (rdata_q),
        .wstrb      (align_wstrb),
        .wdata      (align_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // Request fields come straight from the held EX/MEM bus, which is
    // frozen by stall_req, so they stay stable while req_valid waits on ready.
    assign dmem_addr  = {ex_mem_bus_in.alu_result[XLEN-1:2], 2'b00};
    assign dmem_we    = ex_mem_bus_in.mem_wr;
    assign dmem_wstrb = ex_mem_bus_in.mem_wr ? align_wstrb : 4'h0;
    assign dmem_wdata = align_wdata;

    always_comb begin
        state_d        = state_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        dmem_req_valid = 1'b0;
        stall_req      = 1'b0;

        mem_wb_bus_out.valid        = ex_mem_bus_in.valid;
        mem_wb_bus_out.rd           = ex_mem_bus_in.rd;
        mem_wb_bus_out.reg_wr       = ex_mem_bus_in.reg_wr;
        mem_wb_bus_out.wb_data      = ex_mem_bus_in.alu_result;
        mem_wb_bus_out.misaligned   = 1'b0;
        mem_wb_bus_out.access_fault = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        // Reported to writeback without touching memory.
                        mem_wb_bus_out.misaligned = 1'b1;
                        mem_wb_bus_out.reg_wr     = 1'b0;
                    end else begin
                        dmem_req_valid        = 1'b1;
                        stall_req             = 1'b1;
                        mem_wb_bus_out.valid  = 1'b0;
                        mem_wb_bus_out.reg_wr = 1'b0;
                        cnt_d                 = '0;
                        state_d               = dmem_req_ready ? ST_RESP : ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                dmem_req_valid        = 1'b1;
                stall_req             = 1'b1;
                mem_wb_bus_out.valid  = 1'b0;
                mem_wb_bus_out.reg_wr = 1'b0;
                if (dmem_req_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                stall_req             = 1'b1;
                mem_wb_bus_out.valid  = 1'b0;
                mem_wb_bus_out.reg_wr = 1'b0;
                cnt_d                 = cnt_q + 1'b1;
                if (dmem_rsp_valid) begin
                    rdata_d = dmem_rsp_rdata;
                    err_d   = dmem_rsp_err;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Stall drops here, so the upstream advances at this edge and
                // the same instruction is never seen again in IDLE.
                if (ex_mem_bus_in.mem_rd) begin
                    mem_wb_bus_out.wb_data = load_data;
                end
                mem_wb_bus_out.reg_wr       = ex_mem_bus_in.reg_wr & ~err_q;
                mem_wb_bus_out.access_fault = err_q;
                state_d                     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
